rx_word_fifo: RTL

RX_WORD_FIFO -- requirements
Module: rx_word_fifo

---
 rtl/rx_fifo_pkg.sv | 17 +
 rtl/rx_word_fifo_if.sv | 38 +++
 rtl/rx_fifo_mem.sv | 36 +++
 rtl/rx_word_fifo.sv | 100 ++++++++++
 4 files changed

// File: rtl/rx_fifo_pkg.sv
// ============================================================================
// Module : rx_fifo_pkg
// Brief  : Shared defaults and data-word type for the rx word FIFO slice.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rx_fifo_pkg;

  localparam int RX_FIFO_WIDTH = 8;
  localparam int RX_FIFO_DEPTH = 4;

  typedef logic [RX_FIFO_WIDTH-1:0] rx_word_t;

endpackage : rx_fifo_pkg

`default_nettype wire

// File: rtl/rx_word_fifo_if.sv
// ============================================================================
// Module : rx_word_fifo_if
// Brief  : Upstream/downstream handshake bundle of the rx word FIFO.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface rx_word_fifo_if
  import rx_fifo_pkg::*;
#(
  parameter int WIDTH = RX_FIFO_WIDTH,
  parameter int DEPTH = RX_FIFO_DEPTH
) ();

  localparam int CW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [CW-1:0]    count;
  logic             idle_s;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count, idle_s
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count, idle_s
  );

endinterface : rx_word_fifo_if

`default_nettype wire

// File: rtl/rx_fifo_mem.sv
// ============================================================================
// Module : rx_fifo_mem
// Brief  : DEPTH x WIDTH storage, synchronous write, asynchronous read.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rx_fifo_mem
  import rx_fifo_pkg::*;
#(
  parameter int WIDTH = RX_FIFO_WIDTH,
  parameter int DEPTH = RX_FIFO_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  wire logic             clk,
  input  wire logic             i_we,
  input  wire logic [AW-1:0]    i_waddr,
  input  wire logic [WIDTH-1:0] i_wdata,
  input  wire logic [AW-1:0]    i_raddr,
  output logic      [WIDTH-1:0] o_rdata
);

  // Contents are deliberately not reset; validity is tracked by the count.
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : rx_fifo_mem

`default_nettype wire

// File: rtl/rx_word_fifo.sv
// ============================================================================
// Module : rx_word_fifo
// Brief  : First-word fall-through word FIFO with registered throttle flag.
//          Define RX_WORD_FIFO_STATS_EN to add the word_cnt push counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rx_word_fifo
  import rx_fifo_pkg::*;
#(
  parameter int WIDTH = RX_FIFO_WIDTH,
  parameter int DEPTH = RX_FIFO_DEPTH
) (
  input  wire logic     clk_2,
  input  wire logic     reset_2_n,
  rx_word_fifo_if.slave bus
`ifdef RX_WORD_FIFO_STATS_EN
  ,
  output logic [15:0]   word_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_idle;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_rdata;

  // Flags come from registered state only, so in_ready never depends on out_ready.
  assign w_in_ready  = (r_count != CW'(DEPTH));
  assign w_out_valid = (r_count != '0);
  assign w_push      = bus.in_valid && w_in_ready;
  assign w_pop       = w_out_valid && bus.out_ready;

  always_ff @(posedge clk_2 or negedge reset_2_n) begin
    if (!reset_2_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_idle   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
      // Throttle follows the occupancy of the previous cycle.
      r_idle <= (r_count >= CW'(DEPTH - 1));
    end
  end

  rx_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk_2),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.in_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_rdata;
  assign bus.count     = r_count;
  assign bus.idle_s    = r_idle;

`ifdef RX_WORD_FIFO_STATS_EN
  logic [15:0] r_word_cnt;

  always_ff @(posedge clk_2 or negedge reset_2_n) begin
    if (!reset_2_n) begin
      r_word_cnt <= '0;
    end else if (w_push) begin
      r_word_cnt <= r_word_cnt + 16'd1;
    end
  end

  assign word_cnt = r_word_cnt;
`endif

endmodule : rx_word_fifo

`default_nettype wire
